// File: rtl/fft_pkg.sv
// Shared types and width helpers for the post-FFT analysis path.
package fft_pkg;

  localparam int FFT_N  = 2048;
  localparam int ADC_W  = 12;
  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } fft_cplx_t;

  function automatic int idx_width(input int n_points);
    return $clog2(n_points);
  endfunction

  function automatic int pow_width(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int acc_width(input int dw, input int n_points);
    return pow_width(dw) + idx_width(n_points);
  endfunction

endpackage

// File: rtl/cplx_pow.sv
// Two-stage re^2+im^2 pipeline with a sideband that travels alongside the data.
module cplx_pow #(
  parameter  int DW = 16,
  parameter  int SW = 1,
  localparam int PW = 2 * DW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [SW-1:0]        in_side,
  output logic                 out_valid,
  output logic [PW-1:0]        out_pow,
  output logic [SW-1:0]        out_side
);

  logic signed [2*DW-1:0] re_x, im_x;
  logic signed [2*DW-1:0] rr_q, ii_q;
  logic                   v1_q;
  logic [SW-1:0]          side1_q;

  // Operands widened first so the squares are formed at full product width.
  assign re_x = (2 * DW)'(in_re);
  assign im_x = (2 * DW)'(in_im);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      rr_q      <= '0;
      ii_q      <= '0;
      side1_q   <= '0;
      out_valid <= 1'b0;
      out_pow   <= '0;
      out_side  <= '0;
    end else if (clr) begin
      v1_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      out_valid <= v1_q;
      if (in_valid) begin
        rr_q    <= re_x * re_x;
        ii_q    <= im_x * im_x;
        side1_q <= in_side;
      end
      // Squares are non-negative, so zero-extension gives an exact unsigned sum.
      if (v1_q) begin
        out_pow  <= {1'b0, rr_q} + {1'b0, ii_q};
        out_side <= side1_q;
      end
    end
  end

endmodule

// File: rtl/fft_bin_analyzer.sv
// Post-FFT stage: power stream, per-frame fundamental peak search and in-band power sum.
// s_valid/m_valid are qualify-only strobes: no ready exists, every valid cycle is consumed/presented.
module fft_bin_analyzer
  import fft_pkg::*;
#(
  parameter  int N_POINTS = FFT_N,
  parameter  int DW       = 16,
  parameter  int MIN_BIN  = 2,
  localparam int PW       = pow_width(DW),
  localparam int AW       = acc_width(DW, N_POINTS),
  localparam int IW       = idx_width(N_POINTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  input  logic                 s_last,
  output logic                 m_valid,
  output logic [IW-1:0]        m_bin,
  output logic [PW-1:0]        m_pow,
  output logic                 frame_done,
  output logic [IW-1:0]        peak_bin,
  output logic [PW-1:0]        peak_pow,
  output logic signed [DW-1:0] peak_re,
  output logic signed [DW-1:0] peak_im,
  output logic [AW-1:0]        total_pow,
  output logic                 frame_err
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);
  localparam logic [IW-1:0] HALF_IDX = IW'(N_POINTS / 2);
  localparam logic [IW-1:0] MIN_IDX  = IW'(MIN_BIN);
  localparam int            SW       = 2 * DW + IW + 1;

  logic [IW-1:0] idx;
  logic          accept, at_end, close_in, err_in;

  assign accept   = s_valid && !clr;
  assign at_end   = (idx == LAST_IDX);
  assign close_in = s_last || at_end;
  // Either a premature s_last or a missing one at the final bin.
  assign err_in   = accept && (s_last != at_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (accept) begin
      idx <= close_in ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
    end else if (err_in) begin
      frame_err <= 1'b1;
    end
  end

  // Capture register: pairs each accepted bin with the counter value it arrived under.
  logic                 in_valid_q, in_last_q;
  logic [IW-1:0]        in_idx_q;
  logic signed [DW-1:0] in_re_q, in_im_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_q <= 1'b0;
      in_last_q  <= 1'b0;
      in_idx_q   <= '0;
      in_re_q    <= '0;
      in_im_q    <= '0;
    end else begin
      in_valid_q <= accept;
      if (accept) begin
        in_last_q <= close_in;
        in_idx_q  <= idx;
        in_re_q   <= s_re;
        in_im_q   <= s_im;
      end
    end
  end

  logic [SW-1:0]        pipe_side;
  logic signed [DW-1:0] pipe_re, pipe_im;
  logic                 m_last;

  cplx_pow #(
    .DW(DW),
    .SW(SW)
  ) u_pow (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid_q),
    .in_re    (in_re_q),
    .in_im    (in_im_q),
    .in_side  ({in_re_q, in_im_q, in_idx_q, in_last_q}),
    .out_valid(m_valid),
    .out_pow  (m_pow),
    .out_side (pipe_side)
  );

  assign {pipe_re, pipe_im, m_bin, m_last} = pipe_side;

  logic [PW-1:0]        run_max, nxt_max;
  logic [IW-1:0]        run_bin, nxt_bin;
  logic signed [DW-1:0] run_re, run_im, nxt_re, nxt_im;
  logic [AW-1:0]        run_tot, nxt_tot;
  logic                 in_range, take;

  assign in_range = m_valid && (m_bin >= MIN_IDX) && (m_bin < HALF_IDX);
  // Strict compare: on a tie the earlier (lower) bin is kept.
  assign take     = in_range && (m_pow > run_max);

  always_comb begin
    nxt_max = run_max;
    nxt_bin = run_bin;
    nxt_re  = run_re;
    nxt_im  = run_im;
    nxt_tot = run_tot;
    if (in_range) begin
      nxt_tot = run_tot + AW'(m_pow);
    end
    if (take) begin
      nxt_max = m_pow;
      nxt_bin = m_bin;
      nxt_re  = pipe_re;
      nxt_im  = pipe_im;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max    <= '0;
      run_bin    <= MIN_IDX;
      run_re     <= '0;
      run_im     <= '0;
      run_tot    <= '0;
      frame_done <= 1'b0;
      peak_bin   <= '0;
      peak_pow   <= '0;
      peak_re    <= '0;
      peak_im    <= '0;
      total_pow  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clr) begin
        run_max <= '0;
        run_bin <= MIN_IDX;
        run_re  <= '0;
        run_im  <= '0;
        run_tot <= '0;
      end else if (m_valid && m_last) begin
        // Publish including the closing bin's own contribution, then restart.
        peak_pow   <= nxt_max;
        peak_bin   <= nxt_bin;
        peak_re    <= nxt_re;
        peak_im    <= nxt_im;
        total_pow  <= nxt_tot;
        frame_done <= 1'b1;
        run_max    <= '0;
        run_bin    <= MIN_IDX;
        run_re     <= '0;
        run_im     <= '0;
        run_tot    <= '0;
      end else if (m_valid) begin
        run_max <= nxt_max;
        run_bin <= nxt_bin;
        run_re  <= nxt_re;
        run_im  <= nxt_im;
        run_tot <= nxt_tot;
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_analyzer.sv
// Directed bench for fft_bin_analyzer (N=16): driver pushes expectations, monitor pops and compares.
module tb_fft_bin_analyzer;
  import fft_pkg::*;

  localparam int N   = 16;
  localparam int DW  = 16;
  localparam int MB  = 2;
  localparam int IW  = 4;
  localparam int PW  = 33;
  localparam int AW  = 37;

  typedef struct packed {
    logic [IW-1:0]        bin;
    logic [PW-1:0]        pow;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [AW-1:0]        tot;
    logic                 err;
  } frame_t;

  logic                 clk, rst, clr, s_valid, s_last;
  logic signed [DW-1:0] s_re, s_im;
  logic                 m_valid, frame_done, frame_err;
  logic [IW-1:0]        m_bin, peak_bin;
  logic [PW-1:0]        m_pow, peak_pow;
  logic signed [DW-1:0] peak_re, peak_im;
  logic [AW-1:0]        total_pow;

  fft_bin_analyzer #(.N_POINTS(N), .DW(DW), .MIN_BIN(MB)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_re(s_re), .s_im(s_im),
    .s_last(s_last), .m_valid(m_valid), .m_bin(m_bin), .m_pow(m_pow),
    .frame_done(frame_done), .peak_bin(peak_bin), .peak_pow(peak_pow),
    .peak_re(peak_re), .peak_im(peak_im), .total_pow(total_pow), .frame_err(frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+PW-1:0] exp_q[$];
  int               exp_cyc_q[$];
  frame_t           exp_f_q[$];
  int               done_cyc_q[$];
  frame_t           held_m = '0;
  fft_cplx_t        vec[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pow_of(input int i);
    longint r, m;
    r = vec[i].re;
    m = vec[i].im;
    return PW'(r * r + m * m);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_unexpected: got bin %0d pow %0d expected no output", m_bin, m_pow);
        end else begin
          logic [IW+PW-1:0] e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("m_bin", m_bin, e[IW+PW-1:PW]);
          check("m_pow", m_pow, e[PW-1:0]);
          check("m_latency", cyc, c);
        end
      end
      if (frame_done) begin
        if (exp_f_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: got frame_done=1 expected 0");
        end else begin
          frame_t f;
          int d;
          f = exp_f_q.pop_front();
          d = done_cyc_q.pop_front();
          check("peak_bin", peak_bin, f.bin);
          check("peak_pow", peak_pow, f.pow);
          check("peak_re", peak_re, f.re);
          check("peak_im", peak_im, f.im);
          check("total_pow", total_pow, f.tot);
          check("frame_err", frame_err, f.err);
          check("done_latency", cyc, d);
          held_m = f;
        end
      end else begin
        check("held_bin", peak_bin, held_m.bin);
        check("held_pow", peak_pow, held_m.pow);
        check("held_tot", total_pow, held_m.tot);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) vec[i] = '0;
  endtask

  task automatic set_bin(input int i, input int re, input int im);
    vec[i].re = DW'(re);
    vec[i].im = DW'(im);
  endtask

  task automatic drive_bin(input int i, input bit last, input bit do_clr);
    s_valid = 1'b1;
    s_re    = vec[i].re;
    s_im    = vec[i].im;
    s_last  = last;
    clr     = do_clr;
    @(posedge clk);
    #1;
    if (!do_clr) begin
      exp_q.push_back({IW'(i), pow_of(i)});
      exp_cyc_q.push_back(cyc + 2);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last, input int gap,
                            input logic [IW-1:0] e_bin, input logic [PW-1:0] e_pow,
                            input logic signed [DW-1:0] e_re, input logic signed [DW-1:0] e_im,
                            input logic [AW-1:0] e_tot, input bit e_err, input bit chk_rise);
    frame_t f;
    f.bin = e_bin;
    f.pow = e_pow;
    f.re  = e_re;
    f.im  = e_im;
    f.tot = e_tot;
    f.err = e_err;
    exp_f_q.push_back(f);
    for (int i = 0; i < len; i++) begin
      drive_bin(i, with_last && (i == len - 1), 1'b0);
      if (chk_rise && i == len - 2) check("err_before", frame_err, 0);
      if (chk_rise && i == len - 1) check("err_rise", frame_err, 1);
      if (i == len - 1) done_cyc_q.push_back(cyc + 3);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  // stimulus
  initial begin
    rst = 1'b0;
    clr = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_re = '0;
    s_im = '0;
    clear_vec();
    idle(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_bin", m_bin, 0);
    check("rst_m_pow", m_pow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_pow", peak_pow, 0);
    check("rst_peak_re", peak_re, 0);
    check("rst_peak_im", peak_im, 0);
    check("rst_total_pow", total_pow, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b1;
    idle(2);

    // single tone
    clear_vec();
    set_bin(3, 300, -400);
    send_frame(16, 1, 0, 3, 250000, 300, -400, 250000, 0, 0);
    idle(4);

    // DC and upper half excluded
    clear_vec();
    set_bin(0, 1000, 0);
    set_bin(12, 900, 0);
    set_bin(5, 10, 0);
    check("dc_pow_model", pow_of(0), 1000000);
    send_frame(16, 1, 0, 5, 100, 10, 0, 100, 0, 0);

    // tie keeps lower bin
    clear_vec();
    set_bin(4, 7, 7);
    set_bin(6, 7, 7);
    send_frame(16, 1, 0, 4, 98, 7, 7, 196, 0, 0);

    // extreme value
    clear_vec();
    set_bin(2, -32768, -32768);
    send_frame(16, 1, 0, 2, 33'd2147483648, -32768, -32768, 37'd2147483648, 0, 0);

    // all-zero spectrum
    clear_vec();
    send_frame(16, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    idle(5);

    // mid-frame abort: clr together with bin 7
    clear_vec();
    set_bin(3, 5, 5);
    for (int i = 0; i < 7; i++) drive_bin(i, 1'b0, 1'b0);
    idle(3);
    drive_bin(7, 1'b0, 1'b1);
    idle(8);

    // full frame after abort must not inherit the partial frame
    clear_vec();
    set_bin(6, -100, 50);
    send_frame(16, 1, 0, 6, 12500, -100, 50, 12500, 0, 0);
    idle(5);
    check("err_clean", frame_err, 0);

    // short frame: s_last on bin 9
    clear_vec();
    set_bin(2, 1, 1);
    set_bin(7, 0, -3);
    set_bin(9, 2000, 0);
    send_frame(10, 1, 0, 7, 9, 0, -3, 11, 1, 1);

    // counter restarts at 0 immediately after
    clear_vec();
    set_bin(3, 300, -400);
    send_frame(16, 1, 0, 3, 250000, 300, -400, 250000, 1, 0);

    // missing s_last: wraps at bin 15 and still closes
    clear_vec();
    set_bin(4, 1, 0);
    set_bin(7, -1, -1);
    send_frame(16, 0, 0, 7, 2, -1, -1, 3, 1, 0);

    // streaming with random gaps
    clear_vec();
    set_bin(2, -2, 0);
    set_bin(5, 3, 4);
    send_frame(16, 1, 3, 5, 25, 3, 4, 29, 1, 0);
    clear_vec();
    set_bin(1, 500, 500);
    set_bin(7, 100, 100);
    send_frame(16, 1, 3, 7, 20000, 100, 100, 20000, 1, 0);
    clear_vec();
    set_bin(3, 300, -400);
    send_frame(16, 1, 3, 3, 250000, 300, -400, 250000, 1, 0);

    idle(10);
    check("pow_queue_empty", exp_q.size(), 0);
    check("frame_queue_empty", exp_f_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
